// File: rtl/gb_hls_cfg_seq.sv
// gb_hls_cfg_seq
// AXI4-Lite master that configures and launches the Gaussian-blur hls_target
// core through its s_axi_config port, then waits for completion.
//
// In irq mode it writes GIE<=1, IER<=1 and CTRL<=1. It then waits for the
// interrupt and clears it by writing ISR<=1.
// In poll mode it writes CTRL<=1 only. It then reads CTRL every POLL_GAP idle
// cycles until ap_done (bit 1) is set.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 launch request (accepted in IDLE / ERR only)
//   use_irq               1: wait on interrupt, 0: poll CTRL (sampled at start)
//   interrupt             hls_target interrupt line
//   busy, done, error     status: busy while running, done 1-cycle pulse,
//                         error held until the next accepted start
//   run_cycles            cycles from the CTRL write response until completion
//                         is seen; saturating
//   m_AW*/m_W*/m_B*       AXI4-Lite write channels
//   m_AR*/m_R*            AXI4-Lite read channels
module gb_hls_cfg_seq #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                use_irq,
  input  logic                interrupt,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [31:0]         run_cycles,
  output logic                m_AWVALID,
  input  logic                m_AWREADY,
  output logic [ADDR_W-1:0]   m_AWADDR,
  output logic                m_WVALID,
  input  logic                m_WREADY,
  output logic [DATA_W-1:0]   m_WDATA,
  output logic [DATA_W/8-1:0] m_WSTRB,
  input  logic                m_BVALID,
  output logic                m_BREADY,
  input  logic [1:0]          m_BRESP,
  output logic                m_ARVALID,
  input  logic                m_ARREADY,
  output logic [ADDR_W-1:0]   m_ARADDR,
  input  logic                m_RVALID,
  output logic                m_RREADY,
  input  logic [DATA_W-1:0]   m_RDATA,
  input  logic [1:0]          m_RRESP
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_WRESP, S_GAP, S_RD, S_RDATA, S_CLR, S_CLRRESP, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_GIE  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IER  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_ISR  = ADDR_W'(12);

  // Position in the launch write sequence.
  localparam logic [1:0] STEP_GIE  = 2'd0;
  localparam logic [1:0] STEP_IER  = 2'd1;
  localparam logic [1:0] STEP_CTRL = 2'd2;

  // In irq mode the timeout is expressed in GAP cycles, equivalent to
  // TIMEOUT polls of POLL_GAP idle cycles plus one read each.
  localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);
  localparam logic [31:0] IRQ_LAST  = 32'(TIMEOUT * (POLL_GAP + 1) - 1);
  localparam logic [31:0] POLL_LAST = 32'(TIMEOUT);

  state_t            state_reg, state_next;
  logic              irq_mode_reg, irq_mode_next;
  logic [1:0]        step_reg, step_next;
  logic              aw_valid_reg, aw_valid_next;
  logic              w_valid_reg, w_valid_next;
  logic [ADDR_W-1:0] awaddr_reg, awaddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [31:0]       gap_cnt_reg, gap_cnt_next;
  logic [31:0]       poll_cnt_reg, poll_cnt_next;
  logic [31:0]       run_cycles_reg, run_cycles_next;

  // Only RDATA[1] (ap_done) is of interest.
  logic unused_rdata;
  assign unused_rdata = &{1'b0, m_RDATA[DATA_W-1:2], m_RDATA[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      irq_mode_reg   <= 1'b0;
      step_reg       <= STEP_GIE;
      aw_valid_reg   <= 1'b0;
      w_valid_reg    <= 1'b0;
      awaddr_reg     <= '0;
      wdata_reg      <= '0;
      gap_cnt_reg    <= '0;
      poll_cnt_reg   <= '0;
      run_cycles_reg <= '0;
    end else begin
      state_reg      <= state_next;
      irq_mode_reg   <= irq_mode_next;
      step_reg       <= step_next;
      aw_valid_reg   <= aw_valid_next;
      w_valid_reg    <= w_valid_next;
      awaddr_reg     <= awaddr_next;
      wdata_reg      <= wdata_next;
      gap_cnt_reg    <= gap_cnt_next;
      poll_cnt_reg   <= poll_cnt_next;
      run_cycles_reg <= run_cycles_next;
    end
  end

  logic aw_left, w_left, run_inc;

  always_comb begin
    state_next      = state_reg;
    irq_mode_next   = irq_mode_reg;
    step_next       = step_reg;
    aw_valid_next   = aw_valid_reg;
    w_valid_next    = w_valid_reg;
    awaddr_next     = awaddr_reg;
    wdata_next      = wdata_reg;
    gap_cnt_next    = gap_cnt_reg;
    poll_cnt_next   = poll_cnt_reg;
    run_cycles_next = run_cycles_reg;
    run_inc         = 1'b0;
    // A channel is still pending unless its handshake completes this cycle.
    aw_left         = aw_valid_reg & ~m_AWREADY;
    w_left          = w_valid_reg & ~m_WREADY;

    case (state_reg)
      S_IDLE, S_ERR: begin
        if (start) begin
          irq_mode_next   = use_irq;
          run_cycles_next = '0;
          step_next       = use_irq ? STEP_GIE : STEP_CTRL;
          awaddr_next     = use_irq ? A_GIE : A_CTRL;
          wdata_next      = DATA_W'(1);
          aw_valid_next   = 1'b1;
          w_valid_next    = 1'b1;
          state_next      = S_WR;
        end
      end

      S_WR, S_CLR: begin
        aw_valid_next = aw_left;
        w_valid_next  = w_left;
        if (!aw_left && !w_left) begin
          state_next = (state_reg == S_WR) ? S_WRESP : S_CLRRESP;
        end
      end

      S_WRESP: begin
        if (m_BVALID) begin
          if (m_BRESP != 2'b00) begin
            state_next = S_ERR;
          end else if (step_reg == STEP_CTRL) begin
            gap_cnt_next  = '0;
            poll_cnt_next = '0;
            state_next    = S_GAP;
          end else begin
            step_next     = step_reg + 2'd1;
            awaddr_next   = (step_reg == STEP_GIE) ? A_IER : A_CTRL;
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            state_next    = S_WR;
          end
        end
      end

      S_GAP: begin
        if (irq_mode_reg) begin
          if (interrupt) begin
            awaddr_next   = A_ISR;
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            state_next    = S_CLR;
          end else begin
            run_inc = 1'b1;
            if (gap_cnt_reg == IRQ_LAST) begin
              state_next = S_ERR;
            end else begin
              gap_cnt_next = gap_cnt_reg + 32'd1;
            end
          end
        end else begin
          run_inc = 1'b1;
          if (gap_cnt_reg == GAP_LAST) begin
            state_next = S_RD;
          end else begin
            gap_cnt_next = gap_cnt_reg + 32'd1;
          end
        end
      end

      S_RD: begin
        run_inc = 1'b1;
        if (m_ARREADY) begin
          state_next = S_RDATA;
        end
      end

      S_RDATA: begin
        if (m_RVALID && m_RRESP == 2'b00 && m_RDATA[1]) begin
          state_next = S_DONE;
        end else begin
          run_inc = 1'b1;
          if (m_RVALID) begin
            if (m_RRESP != 2'b00) begin
              state_next = S_ERR;
            end else begin
              poll_cnt_next = poll_cnt_reg + 32'd1;
              gap_cnt_next  = '0;
              state_next    = (poll_cnt_reg + 32'd1 == POLL_LAST) ? S_ERR : S_GAP;
            end
          end
        end
      end

      S_CLRRESP: begin
        if (m_BVALID) begin
          state_next = (m_BRESP != 2'b00) ? S_ERR : S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (run_inc && run_cycles_reg != 32'hFFFF_FFFF) begin
      run_cycles_next = run_cycles_reg + 32'd1;
    end
  end

  assign m_AWVALID  = aw_valid_reg;
  assign m_AWADDR   = awaddr_reg;
  assign m_WVALID   = w_valid_reg;
  assign m_WDATA    = wdata_reg;
  assign m_WSTRB    = '1;
  assign m_BREADY   = (state_reg == S_WRESP) || (state_reg == S_CLRRESP);
  assign m_ARVALID  = (state_reg == S_RD);
  assign m_ARADDR   = A_CTRL;
  assign m_RREADY   = (state_reg == S_RDATA);
  assign busy       = !((state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR));
  assign done       = (state_reg == S_DONE);
  assign error      = (state_reg == S_ERR);
  assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_gb_hls_cfg_seq.sv
// Testbench for gb_hls_cfg_seq: directed launches against a behavioural
// AXI4-Lite slave with programmable AW/W ready delays, write-response error
// injection and a programmable ap_done read sequence.
// d1 uses the default TIMEOUT; d2 uses TIMEOUT=3 for the timeout case.
module tb_gb_hls_cfg_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, use_irq, interrupt, sel, stale_b;
  int   aw_dly, w_dly, bresp_at, rd_done_at, rd_base;
  int   n_tests = 0;
  int   n_fail  = 0;

  // DUT 1 outputs
  logic d1_busy, d1_done, d1_error, d1_awvalid, d1_wvalid, d1_bready, d1_arvalid, d1_rready;
  logic [31:0] d1_run, d1_wdata;
  logic [4:0]  d1_awaddr, d1_araddr;
  logic [3:0]  d1_wstrb;
  // DUT 2 outputs
  logic d2_busy, d2_done, d2_error, d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready;
  logic [31:0] d2_run, d2_wdata;
  logic [4:0]  d2_awaddr, d2_araddr;
  logic [3:0]  d2_wstrb;

  // Slave side
  logic        s_awready, s_wready, s_bvalid, bvalid_s, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  // Master signals of the selected DUT
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        cur_busy, cur_done, cur_error;
  logic [31:0] cur_run, m_wdata;
  logic [4:0]  m_awaddr, m_araddr;

  assign m_awvalid = sel ? d2_awvalid : d1_awvalid;
  assign m_wvalid  = sel ? d2_wvalid  : d1_wvalid;
  assign m_bready  = sel ? d2_bready  : d1_bready;
  assign m_arvalid = sel ? d2_arvalid : d1_arvalid;
  assign m_rready  = sel ? d2_rready  : d1_rready;
  assign m_awaddr  = sel ? d2_awaddr  : d1_awaddr;
  assign m_araddr  = sel ? d2_araddr  : d1_araddr;
  assign m_wdata   = sel ? d2_wdata   : d1_wdata;
  assign cur_busy  = sel ? d2_busy    : d1_busy;
  assign cur_done  = sel ? d2_done    : d1_done;
  assign cur_error = sel ? d2_error   : d1_error;
  assign cur_run   = sel ? d2_run     : d1_run;

  gb_hls_cfg_seq d1 (
    .clk(clk), .rst(rst), .start(start & ~sel), .use_irq(use_irq), .interrupt(interrupt),
    .busy(d1_busy), .done(d1_done), .error(d1_error), .run_cycles(d1_run),
    .m_AWVALID(d1_awvalid), .m_AWREADY(s_awready), .m_AWADDR(d1_awaddr),
    .m_WVALID(d1_wvalid), .m_WREADY(s_wready), .m_WDATA(d1_wdata), .m_WSTRB(d1_wstrb),
    .m_BVALID(s_bvalid), .m_BREADY(d1_bready), .m_BRESP(s_bresp),
    .m_ARVALID(d1_arvalid), .m_ARREADY(s_arready), .m_ARADDR(d1_araddr),
    .m_RVALID(s_rvalid), .m_RREADY(d1_rready), .m_RDATA(s_rdata), .m_RRESP(s_rresp)
  );

  gb_hls_cfg_seq #(.TIMEOUT(3)) d2 (
    .clk(clk), .rst(rst), .start(start & sel), .use_irq(use_irq), .interrupt(interrupt),
    .busy(d2_busy), .done(d2_done), .error(d2_error), .run_cycles(d2_run),
    .m_AWVALID(d2_awvalid), .m_AWREADY(s_awready), .m_AWADDR(d2_awaddr),
    .m_WVALID(d2_wvalid), .m_WREADY(s_wready), .m_WDATA(d2_wdata), .m_WSTRB(d2_wstrb),
    .m_BVALID(s_bvalid), .m_BREADY(d2_bready), .m_BRESP(s_bresp),
    .m_ARVALID(d2_arvalid), .m_ARREADY(s_arready), .m_ARADDR(d2_araddr),
    .m_RVALID(s_rvalid), .m_RREADY(d2_rready), .m_RDATA(s_rdata), .m_RRESP(s_rresp)
  );

  // ---------------- behavioural slave ----------------
  int aw_cyc, w_cyc, wr_n, rd_n;
  logic aw_got, w_got;
  logic [4:0]  addr_cap;
  logic [31:0] data_cap;
  logic [4:0]  wr_addr_log [16];
  logic [31:0] wr_data_log [16];
  int          rd_t [16];
  int          cyc = 0;

  assign s_awready = m_awvalid && (aw_cyc >= aw_dly);
  assign s_wready  = m_wvalid && (w_cyc >= w_dly);
  assign s_arready = m_arvalid;
  assign s_bvalid  = bvalid_s | stale_b;
  assign s_rresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cyc <= 0; w_cyc <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid_s <= 1'b0; s_bresp <= 2'b00; s_rvalid <= 1'b0; s_rdata <= '0;
      wr_n <= 0; rd_n <= 0; addr_cap <= '0; data_cap <= '0;
    end else begin
      if (m_awvalid && s_awready) aw_cyc <= 0;
      else if (m_awvalid)         aw_cyc <= aw_cyc + 1;
      else                        aw_cyc <= 0;
      if (m_wvalid && s_wready)   w_cyc <= 0;
      else if (m_wvalid)          w_cyc <= w_cyc + 1;
      else                        w_cyc <= 0;
      if (m_awvalid && s_awready) begin aw_got <= 1'b1; addr_cap <= m_awaddr; end
      if (m_wvalid && s_wready)   begin w_got  <= 1'b1; data_cap <= m_wdata;  end
      if (aw_got && w_got && !bvalid_s) begin
        bvalid_s <= 1'b1;
        s_bresp  <= (wr_n == bresp_at) ? 2'b10 : 2'b00;
        wr_addr_log[wr_n % 16] <= addr_cap;
        wr_data_log[wr_n % 16] <= data_cap;
        wr_n   <= wr_n + 1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid_s && m_bready) bvalid_s <= 1'b0;
      if (m_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (rd_done_at != 0 && (rd_n - rd_base + 1) >= rd_done_at) ? 32'h6 : 32'h0;
        rd_t[rd_n % 16] <= cyc;
        rd_n <= rd_n + 1;
      end
      if (s_rvalid && m_rready) s_rvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitors ----------------
  int   aw_only = 0, w_only = 0, stab_viol = 0, overlap = 0, bready_viol = 0, araddr_bad = 0;
  logic prev_aw_wait, prev_w_wait;
  logic [4:0]  prev_awaddr;
  logic [31:0] prev_wdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_aw_wait <= 1'b0;
      prev_w_wait  <= 1'b0;
    end else begin
      if (m_awvalid && !m_wvalid) aw_only <= aw_only + 1;
      if (m_wvalid && !m_awvalid) w_only  <= w_only + 1;
      if (m_arvalid && (m_awvalid || m_wvalid)) overlap <= overlap + 1;
      if (m_bready && (m_awvalid || m_wvalid)) bready_viol <= bready_viol + 1;
      if (m_arvalid && m_araddr != 5'd0) araddr_bad <= araddr_bad + 1;
      if ((prev_aw_wait && (!m_awvalid || m_awaddr != prev_awaddr)) ||
          (prev_w_wait && (!m_wvalid || m_wdata != prev_wdata)))
        stab_viol <= stab_viol + 1;
      prev_aw_wait <= m_awvalid && !s_awready;
      prev_w_wait  <= m_wvalid && !s_wready;
      prev_awaddr  <= m_awaddr;
      prev_wdata   <= m_wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic launch(input logic irq);
    @(negedge clk);
    start   = 1'b1;
    use_irq = irq;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Runs until busy drops; returns number of done pulses seen.
  task automatic wait_end(input string tag, input int max, output int dcnt);
    dcnt = 0;
    for (int i = 0; i < max; i++) begin
      if (cur_done) dcnt++;
      if (!cur_busy) break;
      @(negedge clk);
    end
    check_eq({tag, "_tmo"}, {31'd0, cur_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int dc, wr0, rd0, ao0, wo0, i;

  initial begin
    rst = 1'b1; start = 1'b0; use_irq = 1'b0; interrupt = 1'b0; sel = 1'b0; stale_b = 1'b0;
    aw_dly = 0; w_dly = 0; bresp_at = -1; rd_done_at = 0; rd_base = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",    {31'd0, d1_busy},    32'd0);
    check_eq("rst_done",    {31'd0, d1_done},    32'd0);
    check_eq("rst_error",   {31'd0, d1_error},   32'd0);
    check_eq("rst_run",     d1_run,              32'd0);
    check_eq("rst_awvalid", {31'd0, d1_awvalid}, 32'd0);
    check_eq("rst_arvalid", {31'd0, d1_arvalid}, 32'd0);
    check_eq("rst_bready",  {31'd0, d1_bready},  32'd0);
    check_eq("rst_wstrb",   {28'd0, d1_wstrb},   32'hF);
    check_eq("rst_wdata",   d1_wdata,            32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Poll mode, ap_done on third read
    wr0 = wr_n; rd0 = rd_n; rd_base = rd_n; rd_done_at = 3;
    launch(1'b0);
    check_eq("poll_busy", {31'd0, cur_busy}, 32'd1);
    wait_end("poll", 300, dc);
    check_eq("poll_done_cnt", dc, 32'd1);
    check_eq("poll_error", {31'd0, cur_error}, 32'd0);
    check_eq("poll_run", cur_run, 32'd17);
    check_eq("poll_nwr", wr_n - wr0, 32'd1);
    check_eq("poll_awaddr", {27'd0, wr_addr_log[wr0 % 16]}, 32'h0);
    check_eq("poll_wdata", wr_data_log[wr0 % 16], 32'h1);
    check_eq("poll_nrd", rd_n - rd0, 32'd3);
    check_eq("poll_sp1", rd_t[(rd0 + 1) % 16] - rd_t[rd0 % 16], 32'd6);
    check_eq("poll_sp2", rd_t[(rd0 + 2) % 16] - rd_t[(rd0 + 1) % 16], 32'd6);
    @(negedge clk);
    check_eq("poll_done_after", {31'd0, cur_done}, 32'd0);
    check_eq("poll_run_hold", cur_run, 32'd17);

    // Irq mode, interrupt 50 cycles after the CTRL write response
    wr0 = wr_n; rd0 = rd_n;
    launch(1'b1);
    i = 0;
    while (wr_n - wr0 != 3 && i < 200) begin @(negedge clk); i++; end
    check_eq("irq_wr_tmo", {31'd0, (i >= 200)}, 32'd0);
    repeat (50) @(negedge clk);
    interrupt = 1'b1;
    wait_end("irq", 100, dc);
    interrupt = 1'b0;
    check_eq("irq_done_cnt", dc, 32'd1);
    check_eq("irq_nwr", wr_n - wr0, 32'd4);
    check_eq("irq_a0", {27'd0, wr_addr_log[wr0 % 16]}, 32'h4);
    check_eq("irq_a1", {27'd0, wr_addr_log[(wr0 + 1) % 16]}, 32'h8);
    check_eq("irq_a2", {27'd0, wr_addr_log[(wr0 + 2) % 16]}, 32'h0);
    check_eq("irq_a3", {27'd0, wr_addr_log[(wr0 + 3) % 16]}, 32'hC);
    check_eq("irq_d1", wr_data_log[(wr0 + 1) % 16], 32'h1);
    check_eq("irq_d3", wr_data_log[(wr0 + 3) % 16], 32'h1);
    check_eq("irq_nrd", rd_n - rd0, 32'd0);
    check_eq("irq_run", cur_run, 32'd49);

    // Skewed handshakes: WREADY late, then AWREADY late
    ao0 = aw_only; wo0 = w_only;
    aw_dly = 0; w_dly = 5; rd_base = rd_n; rd_done_at = 1;
    launch(1'b0);
    wait_end("skw1", 200, dc);
    check_eq("skw1_done", dc, 32'd1);
    check_eq("skw1_w_only", w_only - wo0, 32'd5);
    check_eq("skw1_aw_only", aw_only - ao0, 32'd0);
    check_eq("skw1_run", cur_run, 32'd5);
    ao0 = aw_only; wo0 = w_only;
    aw_dly = 5; w_dly = 0; rd_base = rd_n;
    launch(1'b0);
    wait_end("skw2", 200, dc);
    aw_dly = 0;
    check_eq("skw2_done", dc, 32'd1);
    check_eq("skw2_aw_only", aw_only - ao0, 32'd5);
    check_eq("skw2_w_only", w_only - wo0, 32'd0);
    check_eq("stable", stab_viol, 32'd0);
    check_eq("bready_early", bready_viol, 32'd0);
    check_eq("ar_aw_overlap", overlap, 32'd0);
    check_eq("araddr", araddr_bad, 32'd0);

    // Write error on CTRL, then relaunch
    bresp_at = wr_n; rd_done_at = 1; rd_base = rd_n;
    launch(1'b0);
    wait_end("berr", 100, dc);
    check_eq("berr_error", {31'd0, cur_error}, 32'd1);
    check_eq("berr_done", dc, 32'd0);
    wr0 = wr_n; rd0 = rd_n;
    repeat (10) @(negedge clk);
    check_eq("berr_sticky", {31'd0, cur_error}, 32'd1);
    check_eq("berr_no_wr", wr_n - wr0, 32'd0);
    check_eq("berr_no_rd", rd_n - rd0, 32'd0);
    bresp_at = -1; rd_base = rd_n;
    launch(1'b0);
    check_eq("relaunch_err_clr", {31'd0, cur_error}, 32'd0);
    check_eq("relaunch_busy", {31'd0, cur_busy}, 32'd1);
    wait_end("relaunch", 200, dc);
    check_eq("relaunch_done", dc, 32'd1);

    // Timeout on the TIMEOUT=3 instance, ap_done never set
    sel = 1'b1; rd_done_at = 0; rd0 = rd_n;
    launch(1'b0);
    wait_end("tmo", 300, dc);
    check_eq("tmo_error", {31'd0, cur_error}, 32'd1);
    check_eq("tmo_nrd", rd_n - rd0, 32'd3);
    check_eq("tmo_run", cur_run, 32'd18);
    sel = 1'b0;

    // Asynchronous reset in the middle of a write
    aw_dly = 10;
    launch(1'b0);
    @(negedge clk);
    check_eq("mid_awvalid", {31'd0, d1_awvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_awvalid", {31'd0, d1_awvalid}, 32'd0);
    check_eq("arst_wvalid", {31'd0, d1_wvalid}, 32'd0);
    check_eq("arst_busy", {31'd0, d1_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0; stale_b = 1'b1; aw_dly = 0;
    repeat (3) @(negedge clk);
    check_eq("stale_busy", {31'd0, d1_busy}, 32'd0);
    check_eq("stale_bready", {31'd0, d1_bready}, 32'd0);
    check_eq("arst_run", d1_run, 32'd0);
    stale_b = 1'b0; rd_base = rd_n; rd_done_at = 1;
    launch(1'b0);
    wait_end("post_rst", 200, dc);
    check_eq("post_rst_done", dc, 32'd1);
    check_eq("post_rst_error", {31'd0, d1_error}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
